// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared sizing and reset constants for register_file.
package reg_file_pkg;
   localparam int RF_DATA_WIDTH = 16;
   localparam int RF_ADDR_WIDTH = 3;
   localparam int RF_DEPTH = 2 ** RF_ADDR_WIDTH;
   localparam logic [RF_DATA_WIDTH-1:0] RF_RESET_VAL = '0;
endpackage

// File: rtl/register_file.sv
// register_file: single-port register file with registered read data.
// Define REG_FILE_RD_VALID_EN to add the RdData_Valid read strobe output.
module register_file
   import reg_file_pkg::*;
#(
   parameter int DATA_WIDTH = RF_DATA_WIDTH,
   parameter int ADDR_WIDTH = RF_ADDR_WIDTH
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  WrEn,
   input  logic                  RdEn,
   input  logic [ADDR_WIDTH-1:0] Address,
   input  logic [DATA_WIDTH-1:0] WrData,
`ifdef REG_FILE_RD_VALID_EN
   output logic                  RdData_Valid,
`endif
   output logic [DATA_WIDTH-1:0] RdData
);
   localparam int DEPTH = 2 ** ADDR_WIDTH;
   logic [DATA_WIDTH-1:0] Reg_File [0:DEPTH-1];
   // A simultaneous write wins; the read is dropped and RdData holds.
   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < DEPTH; i++) Reg_File[i] <= DATA_WIDTH'(RF_RESET_VAL);
         RdData <= DATA_WIDTH'(RF_RESET_VAL);
      end else if (WrEn) Reg_File[Address] <= WrData;
      else if (RdEn) RdData <= Reg_File[Address];
   end
`ifdef REG_FILE_RD_VALID_EN
   always_ff @(posedge CLK) RdData_Valid <= !RST && RdEn && !WrEn;
`endif
endmodule

// File: tb/tb_register_file.sv
// tb_register_file: directed and random checks of register_file against a word-array model.
module tb_register_file;
   logic CLK = 1'b0;
   logic RST, WrEn, RdEn;
   logic [2:0] Address;
   logic [15:0] WrData, RdData;
   logic rdValid;
   int vectors = 0, miscompares = 0;
   logic [15:0] mem [0:7];
   logic [15:0] expRd;
   logic expValid;
   bit armed = 1'b0;
   always #5 CLK = ~CLK;
   register_file dut (
      .CLK(CLK), .RST(RST), .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
`ifdef REG_FILE_RD_VALID_EN
      .RdData_Valid(rdValid),
`endif
      .RdData(RdData)
   );
`ifndef REG_FILE_RD_VALID_EN
   assign rdValid = 1'b0;
`endif
   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask
   // Model: a plain word array plus the last value a performed read returned.
   always @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < 8; i++) mem[i] = 16'h0;
         expRd = 16'h0;
         expValid = 1'b0;
         armed = 1'b1;
      end else begin
         expValid = RdEn && !WrEn;
         if (WrEn) mem[Address] = WrData;
         else if (RdEn) expRd = mem[Address];
      end
   end
   always @(negedge CLK) if (armed) begin
      chk("rdData", RdData, expRd);
      for (int i = 0; i < 8; i++) chk($sformatf("word%0d", i), dut.Reg_File[i], mem[i]);
`ifdef REG_FILE_RD_VALID_EN
      chk("rdValid", {15'b0, rdValid}, {15'b0, expValid});
`endif
   end
   task automatic tick(input logic r, input logic w, input logic rd, input logic [2:0] a, input logic [15:0] d);
      RST = r; WrEn = w; RdEn = rd; Address = a; WrData = d;
      @(negedge CLK);
   endtask
   initial begin
      tick(1, 0, 0, 0, 0);
      tick(0, 1, 0, 5, 16'h1234);
      tick(0, 1, 0, 1, 16'h0055);
      tick(1, 1, 1, 5, 16'hFFFF);
      for (int i = 0; i < 8; i++) chk("resetWord", dut.Reg_File[i], 16'h0);
      chk("resetRd", RdData, 16'h0);
      tick(0, 1, 0, 5, 16'd10);
      chk("write5", dut.Reg_File[5], 16'd10);
      tick(0, 0, 1, 5, 16'h0);
      chk("read5", RdData, 16'd10);
`ifdef REG_FILE_RD_VALID_EN
      chk("valid5", {15'b0, rdValid}, 16'd1);
`endif
      tick(0, 1, 0, 2, 16'd3);
      tick(0, 0, 1, 2, 16'h0);
      chk("read2", RdData, 16'd3);
      chk("word2", dut.Reg_File[2], 16'd3);
      chk("keep5", dut.Reg_File[5], 16'd10);
      tick(0, 1, 1, 2, 16'hBEEF);
      chk("bothWr", dut.Reg_File[2], 16'hBEEF);
      chk("bothRd", RdData, 16'd3);
`ifdef REG_FILE_RD_VALID_EN
      chk("bothValid", {15'b0, rdValid}, 16'd0);
`endif
      tick(0, 0, 0, 2, 16'h0);
      chk("idleRd", RdData, 16'd3);
      for (int i = 0; i < 8; i++) tick(0, 1, 0, 3'(i), 16'hA000 + 16'(i) * 16'h0111);
      for (int i = 0; i < 8; i++) begin
         tick(0, 0, 1, 3'(i), 16'h0);
         chk("sweepRd", RdData, 16'hA000 + 16'(i) * 16'h0111);
      end
      for (int n = 0; n < 400; n++)
         tick($urandom_range(0, 39) == 0, 1'($urandom), 1'($urandom), 3'($urandom), 16'($urandom));
      tick(0, 0, 0, 0, 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
